// File: rtl/deco_pipe.sv
// Decode stage: splits an instruction into operands, reads a register file with
// write-back forwarding, and tracks per-register busy bits for hazard stalls.
module deco_pipe #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int INSTR_W  = 32,
    localparam int RA_W    = $clog2(NUM_REGS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               wb_en,
    input  logic [RA_W-1:0]    wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         opcode,
    output logic [DATA_W-1:0]  rd,
    output logic [DATA_W-1:0]  rs,
    output logic [DATA_W-1:0]  rt,
    output logic [DATA_W-1:0]  rsi,
    output logic               illegal
);

    localparam int IMM_W  = INSTR_W - 5 - RA_W;
    localparam int IMM2_W = INSTR_W - 5 - 2 * RA_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic [4:0]        op_in;
    logic [RA_W-1:0]   ra, rb, rc;
    logic [DATA_W-1:0] imm, imm2;
    logic [DATA_W-1:0] val_ra, val_rb, val_rc;
    logic              busy_ra, busy_rb, busy_rc;
    logic              wb_live;

    assign op_in = instr[INSTR_W-1 -: 5];
    assign ra    = instr[INSTR_W-6 -: RA_W];
    assign rb    = instr[INSTR_W-6-RA_W -: RA_W];
    assign rc    = instr[INSTR_W-6-2*RA_W -: RA_W];
    assign imm   = DATA_W'(instr[IMM_W-1:0]);
    assign imm2  = DATA_W'(instr[IMM2_W-1:0]);

    // Write-back to r0 is dropped everywhere, including forwarding.
    assign wb_live = reset && wb_en && (wb_addr != '0);

    assign val_ra = (ra == '0) ? '0 : (wb_live && wb_addr == ra) ? wb_data : regs[ra];
    assign val_rb = (rb == '0) ? '0 : (wb_live && wb_addr == rb) ? wb_data : regs[rb];
    assign val_rc = (rc == '0) ? '0 : (wb_live && wb_addr == rc) ? wb_data : regs[rc];

    assign busy_ra = busy[ra] && !(wb_live && wb_addr == ra);
    assign busy_rb = busy[rb] && !(wb_live && wb_addr == rb);
    assign busy_rc = busy[rc] && !(wb_live && wb_addr == rc);

    logic [DATA_W-1:0] d_rd, d_rs, d_rt, d_rsi;
    logic d_illegal, use_ra, use_rb, use_rc, dst, hazard, accept;

    always_comb begin
        d_rd      = '0;
        d_rs      = '0;
        d_rt      = '0;
        d_rsi     = '0;
        d_illegal = 1'b0;
        use_ra    = 1'b0;
        use_rb    = 1'b0;
        use_rc    = 1'b0;
        dst       = 1'b0;
        case (op_in)
            5'd1: begin
                d_rd  = DATA_W'(ra);
                d_rsi = imm;
                dst   = 1'b1;
            end
            5'd2, 5'd3, 5'd4, 5'd5: begin
                d_rd   = DATA_W'(ra);
                d_rs   = val_rb;
                d_rt   = val_rc;
                use_rb = 1'b1;
                use_rc = 1'b1;
                dst    = 1'b1;
            end
            5'd6: begin
                d_rd   = DATA_W'(ra);
                d_rsi  = val_rb;
                use_rb = 1'b1;
                dst    = 1'b1;
            end
            5'd7: d_rd = imm;
            5'd8: begin
                d_rd   = val_ra;
                d_rs   = val_rb;
                d_rt   = imm2;
                use_ra = 1'b1;
                use_rb = 1'b1;
            end
            5'd9: begin
                d_rd   = DATA_W'(ra);
                d_rs   = val_ra;
                d_rt   = val_rb;
                use_ra = 1'b1;
                use_rb = 1'b1;
                dst    = 1'b1;
            end
            5'd10: begin
                d_rs   = val_ra;
                use_ra = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
    end

    // The destination is always ra, so WAW reuses the ra busy check.
    assign hazard   = (use_ra && busy_ra) || (use_rb && busy_rb) ||
                      (use_rc && busy_rc) || (dst && busy_ra);
    assign in_ready = reset && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Busy set is applied after the write-back clear so a same-cycle set wins.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy      <= '0;
            out_valid <= 1'b0;
            opcode    <= '0;
            rd        <= '0;
            rs        <= '0;
            rt        <= '0;
            rsi       <= '0;
            illegal   <= 1'b0;
        end else begin
            if (wb_live) begin
                regs[wb_addr] <= wb_data;
                busy[wb_addr] <= 1'b0;
            end
            if (accept && dst && ra != '0) begin
                busy[ra] <= 1'b1;
            end
            if (accept) begin
                out_valid <= 1'b1;
                opcode    <= op_in;
                rd        <= d_rd;
                rs        <= d_rs;
                rt        <= d_rt;
                rsi       <= d_rsi;
                illegal   <= d_illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_deco_pipe.sv
// Directed bench for deco_pipe: decode, hazards, forwarding, stall, reset,
// plus a 64-register / 16-bit build.
module tb_deco_pipe;

    logic        clock;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [4:0]  opcode;
    logic [31:0] rd, rs, rt, rsi;
    logic        illegal;

    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, illegal_w;
    logic [31:0] instr_w;
    logic [4:0]  opcode_w;
    logic [15:0] rd_w, rs_w, rt_w, rsi_w;
    logic        wb_en_w;
    logic [5:0]  wb_addr_w;
    logic [15:0] wb_data_w;

    int compared;
    int mismatched;

    deco_pipe dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .rsi(rsi), .illegal(illegal)
    );

    deco_pipe #(.DATA_W(16), .NUM_REGS(64), .INSTR_W(32)) dut_w (
        .clock(clock), .reset(reset),
        .in_valid(in_valid_w), .in_ready(in_ready_w), .instr(instr_w),
        .wb_en(wb_en_w), .wb_addr(wb_addr_w), .wb_data(wb_data_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .opcode(opcode_w), .rd(rd_w), .rs(rs_w), .rt(rt_w), .rsi(rsi_w), .illegal(illegal_w)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        tick();
        wb_en   = 1'b0;
    endtask

    task automatic send(input logic [31:0] i);
        in_valid = 1'b1;
        instr    = i;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b1;
        instr = {5'd1, 5'd2, 22'd3};
        out_ready = 1'b1;
        tick();
        tick();
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready got %0b want 0", in_ready); end
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
        compared++;
        if ({opcode, rd, rs, rt, rsi, illegal} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs got op=%0d rd=%h rs=%h rt=%h rsi=%h ill=%0b want all 0", opcode, rd, rs, rt, rsi, illegal);
        end
        in_valid = 1'b0;
        instr = '0;
        reset = 1'b1;
        tick();
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL idle_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_alu();
        write_reg(5'd3, 32'h11);
        write_reg(5'd4, 32'h22);
        send({5'd2, 5'd5, 5'd3, 5'd4, 12'd0});
        compared++;
        if (out_valid !== 1'b1 || opcode !== 5'd2 || rd !== 32'd5 || rs !== 32'h11 || rt !== 32'h22 || rsi !== 32'd0 || illegal !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL alu_bundle got v=%0b op=%0d rd=%h rs=%h rt=%h rsi=%h want 1/2/5/11/22/0", out_valid, opcode, rd, rs, rt, rsi);
        end
        compared++;
        if (dut.busy[5] !== 1'b1) begin mismatched++; $display("[TB] FAIL alu_busy5 got %0b want 1", dut.busy[5]); end
        tick();
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL alu_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_hazard_forward();
        in_valid = 1'b1;
        instr = {5'd2, 5'd6, 5'd5, 5'd3, 12'd0};
        #1;
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL raw_stall got %0b want 0", in_ready); end
        tick();
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL raw_no_accept got %0b want 0", out_valid); end
        wb_en = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'h99;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL fwd_ready got %0b want 1", in_ready); end
        tick();
        wb_en = 1'b0;
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b1 || rd !== 32'd6 || rs !== 32'h99 || rt !== 32'h11) begin
            mismatched++;
            $display("[TB] FAIL fwd_bundle got v=%0b rd=%h rs=%h rt=%h want 1/6/99/11", out_valid, rd, rs, rt);
        end
        compared++;
        if (dut.busy[5] !== 1'b0 || dut.busy[6] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL fwd_busy got b5=%0b b6=%0b want 0/1", dut.busy[5], dut.busy[6]);
        end
        in_valid = 1'b1;
        instr = {5'd1, 5'd6, 22'd1};
        #1;
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL waw_stall got %0b want 0", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        write_reg(5'd6, 32'h66);
        in_valid = 1'b1;
        instr = {5'd1, 5'd7, 22'h55};
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_ready[%0d] got %0b want 0", i, in_ready); end
            tick();
            compared++;
            if (out_valid !== 1'b1 || opcode !== 5'd2 || rd !== 32'd6 || rs !== 32'h99 || rt !== 32'h11) begin
                mismatched++;
                $display("[TB] FAIL stall_hold[%0d] got v=%0b op=%0d rd=%h rs=%h rt=%h want 1/2/6/99/11", i, out_valid, opcode, rd, rs, rt);
            end
        end
        out_ready = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL release_ready got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b1 || opcode !== 5'd1 || rd !== 32'd7 || rsi !== 32'h55 || rs !== 32'd0 || rt !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL lv_bundle got v=%0b op=%0d rd=%h rsi=%h rs=%h rt=%h want 1/1/7/55/0/0", out_valid, opcode, rd, rsi, rs, rt);
        end
    endtask

    task automatic test_reset_stall();
        write_reg(5'd7, 32'h77);
        out_ready = 1'b0;
        send({5'd1, 5'd7, 22'd1});
        compared++;
        if (out_valid !== 1'b1 || dut.busy[7] !== 1'b1 || dut.regs[7] !== 32'h77) begin
            mismatched++;
            $display("[TB] FAIL pre_reset got v=%0b b7=%0b r7=%h want 1/1/77", out_valid, dut.busy[7], dut.regs[7]);
        end
        reset = 1'b0;
        wb_en = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'hAB;
        in_valid = 1'b1;
        instr = {5'd1, 5'd9, 22'd2};
        #1;
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall_ready got %0b want 0", in_ready); end
        tick();
        reset = 1'b1;
        wb_en = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        compared++;
        if (out_valid !== 1'b0 || rd !== 32'd0 || rsi !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_discard got v=%0b rd=%h rsi=%h want 0/0/0", out_valid, rd, rsi);
        end
        compared++;
        if (dut.busy !== 32'd0 || dut.regs[7] !== 32'd0 || dut.regs[3] !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_state got busy=%h r7=%h r3=%h want 0/0/0", dut.busy, dut.regs[7], dut.regs[3]);
        end
    endtask

    task automatic test_decode();
        write_reg(5'd2, 32'h20);
        write_reg(5'd3, 32'h30);
        send({5'd8, 5'd2, 5'd3, 17'h1ABCD});
        compared++;
        if (opcode !== 5'd8 || rd !== 32'h20 || rs !== 32'h30 || rt !== 32'h1ABCD || rsi !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL beq got op=%0d rd=%h rs=%h rt=%h rsi=%h want 8/20/30/1abcd/0", opcode, rd, rs, rt, rsi);
        end
        send({5'd6, 5'd4, 5'd3, 17'd0});
        compared++;
        if (opcode !== 5'd6 || rd !== 32'd4 || rsi !== 32'h30 || rs !== 32'd0 || rt !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL cp got op=%0d rd=%h rsi=%h rs=%h rt=%h want 6/4/30/0/0", opcode, rd, rsi, rs, rt);
        end
        send({5'd7, 5'd1, 22'h2ABCDE});
        compared++;
        if (opcode !== 5'd7 || rd !== 32'h2ABCDE || dut.busy[1] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL branch got op=%0d rd=%h b1=%0b want 7/2abcde/0", opcode, rd, dut.busy[1]);
        end
        send({5'd9, 5'd2, 5'd3, 17'd0});
        compared++;
        if (opcode !== 5'd9 || rd !== 32'd2 || rs !== 32'h20 || rt !== 32'h30 || dut.busy[2] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL slr got op=%0d rd=%h rs=%h rt=%h b2=%0b want 9/2/20/30/1", opcode, rd, rs, rt, dut.busy[2]);
        end
        wb_en = 1'b1;
        wb_addr = 5'd8;
        wb_data = 32'h88;
        send({5'd1, 5'd8, 22'd5});
        wb_en = 1'b0;
        compared++;
        if (dut.busy[8] !== 1'b1 || dut.regs[8] !== 32'h88 || rd !== 32'd8) begin
            mismatched++;
            $display("[TB] FAIL set_wins got b8=%0b r8=%h rd=%h want 1/88/8", dut.busy[8], dut.regs[8], rd);
        end
    endtask

    task automatic test_r0_illegal();
        write_reg(5'd0, 32'hFFFF);
        compared++;
        if (dut.regs[0] !== 32'd0) begin mismatched++; $display("[TB] FAIL r0_write got %h want 0", dut.regs[0]); end
        send({5'd10, 5'd0, 22'd0});
        compared++;
        if (out_valid !== 1'b1 || opcode !== 5'd10 || rs !== 32'd0 || rd !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL gp_r0 got v=%0b op=%0d rs=%h rd=%h want 1/10/0/0", out_valid, opcode, rs, rd);
        end
        send({5'd15, 5'd9, 5'd3, 5'd2, 12'd0});
        compared++;
        if (illegal !== 1'b1 || opcode !== 5'd15 || rd !== 32'd0 || rs !== 32'd0 || rt !== 32'd0 || rsi !== 32'd0 || dut.busy[9] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL illegal got ill=%0b op=%0d rd=%h rs=%h rt=%h rsi=%h b9=%0b want 1/15/0/0/0/0/0", illegal, opcode, rd, rs, rt, rsi, dut.busy[9]);
        end
    endtask

    task automatic test_wide();
        in_valid_w = 1'b1;
        instr_w = {5'd1, 6'd63, 21'h1F1234};
        tick();
        in_valid_w = 1'b0;
        compared++;
        if (out_valid_w !== 1'b1 || opcode_w !== 5'd1 || rd_w !== 16'd63 || rsi_w !== 16'h1234) begin
            mismatched++;
            $display("[TB] FAIL wide_lv got v=%0b op=%0d rd=%h rsi=%h want 1/1/3f/1234", out_valid_w, opcode_w, rd_w, rsi_w);
        end
        compared++;
        if (dut_w.busy[63] !== 1'b1) begin mismatched++; $display("[TB] FAIL wide_busy63 got %0b want 1", dut_w.busy[63]); end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        reset = 1'b0;
        in_valid = 1'b0;
        instr = '0;
        wb_en = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        out_ready = 1'b1;
        in_valid_w = 1'b0;
        instr_w = '0;
        wb_en_w = 1'b0;
        wb_addr_w = '0;
        wb_data_w = '0;
        out_ready_w = 1'b1;

        test_reset();
        test_alu();
        test_hazard_forward();
        test_stall();
        test_reset_stall();
        test_decode();
        test_r0_illegal();
        test_wide();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
